bus_mux_pipe: RTL

//  Parametrised, pipelined source selector for the processor datapath bus.

---
 rtl/bus_pkg.sv | 43 ++++
 rtl/skid_fifo2.sv | 70 +++++++
 rtl/bus_mux_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus selector.
//  - Opcode constants for the MV / MVT instruction formats.
//  - Select-code offsets of the immediate and DIN sources, relative to NUM_REGS.
//  - fmt_imm: builds the bus immediate from an IR word of any width up to MAX_W.
package bus_pkg;

    localparam int unsigned MAX_W       = 64;
    localparam int unsigned OPC_MV      = 0;
    localparam int unsigned OPC_MVT     = 1;
    localparam int unsigned SEL_IMM_OFS = 0;
    localparam int unsigned SEL_DIN_OFS = 1;

    // MVT opcode places the low half of IR in the top half of the word.
    // Any other opcode sign-extends the low imm_w bits.
    // Widths are arguments so that a constant call folds to plain wiring.
    function automatic logic [MAX_W-1:0] fmt_imm(
        input logic [MAX_W-1:0] ir,
        input int unsigned      data_w,
        input int unsigned      imm_w,
        input int unsigned      opc_w,
        input logic [MAX_W-1:0] mvt_opc
    );
        logic [MAX_W-1:0] opc;
        logic [MAX_W-1:0] m_imm;
        logic [MAX_W-1:0] m_half;
        logic [MAX_W-1:0] m_data;
        logic [MAX_W-1:0] res;
        m_imm  = (MAX_W'(1) << imm_w) - MAX_W'(1);
        m_half = (MAX_W'(1) << (data_w / 2)) - MAX_W'(1);
        m_data = (data_w >= MAX_W) ? '1 : ((MAX_W'(1) << data_w) - MAX_W'(1));
        opc    = (ir >> (data_w - opc_w)) & ((MAX_W'(1) << opc_w) - MAX_W'(1));
        if (opc == mvt_opc) begin
            res = (ir & m_half) << (data_w / 2);
        end else begin
            res = ir & m_imm;
            if (((ir >> (imm_w - 1)) & MAX_W'(1)) != '0) begin
                res = res | ~m_imm;
            end
        end
        return res & m_data;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready buffer; all outputs come straight from registers.
//  clk, resetn         clock, async active-low reset (discards contents)
//  in_data/valid/ready upstream handshake, in_ready = occupancy != 2
//  out_data/valid/ready downstream handshake, out_data = oldest entry
module skid_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] r_q0;
    logic [W-1:0] r_q1;
    logic [1:0]   r_cnt;
    logic         r_vld;
    logic         r_rdy;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_push = in_valid & r_rdy;
    assign w_pop  = out_ready & r_vld;

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_pop) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (w_pop && !w_push) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // Storage: q0 is the head, q1 only ever holds the second word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q0  <= '0;
            r_q1  <= '0;
            r_cnt <= 2'd0;
            r_vld <= 1'b0;
            r_rdy <= 1'b1;
        end else begin
            if (w_push && w_pop) begin
                r_q0 <= in_data;
            end else if (w_push) begin
                if (r_cnt == 2'd0) begin
                    r_q0 <= in_data;
                end else begin
                    r_q1 <= in_data;
                end
            end else if (w_pop) begin
                r_q0 <= r_q1;
            end
            r_cnt <= w_cnt_nxt;
            r_vld <= (w_cnt_nxt != 2'd0);
            r_rdy <= (w_cnt_nxt != 2'd2);
        end
    end

    assign in_ready  = r_rdy;
    assign out_valid = r_vld;
    assign out_data  = r_q0;

endmodule

// File: rtl/bus_mux_pipe.sv
// Pipelined bus source selector: register file, formatted immediate or DIN,
// buffered through skid_fifo2 with a sticky illegal-select error.
//  clk, resetn            clock, async active-low reset
//  regs_flat              NUM_REGS packed register outputs
//  ir, din                immediate source and external data
//  in_sel/valid/ready     select request handshake
//  out_data/sel/valid/ready  buffered bus word and its select code
//  err, err_sel, err_clr  sticky illegal-select flag, first code, clear
module bus_mux_pipe
    import bus_pkg::*;
#(
    parameter  int unsigned          DATA_W   = 16,
    parameter  int unsigned          NUM_REGS = 8,
    parameter  int unsigned          IMM_W    = 9,
    parameter  int unsigned          OPC_W    = 3,
    parameter  logic [OPC_W-1:0]     MVT_OPC  = OPC_W'(OPC_MVT),
    localparam int unsigned          SEL_W    = $clog2(NUM_REGS + 2)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    input  logic [DATA_W-1:0]          ir,
    input  logic [DATA_W-1:0]          din,
    input  logic [SEL_W-1:0]           in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [SEL_W-1:0]           out_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       err,
    output logic [SEL_W-1:0]           err_sel,
    input  logic                       err_clr
);

    localparam int unsigned PAY_W   = SEL_W + DATA_W;
    localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(NUM_REGS + SEL_IMM_OFS);
    localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(NUM_REGS + SEL_DIN_OFS);

    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_data;
    logic              w_illegal;
    logic              w_accept;
    logic [PAY_W-1:0]  w_q;
    logic              r_err;
    logic [SEL_W-1:0]  r_err_sel;

    assign w_imm = DATA_W'(fmt_imm(MAX_W'(ir), DATA_W, IMM_W, OPC_W, MAX_W'(MVT_OPC)));

    // Source select; illegal codes fall through to data 0.
    always_comb begin
        w_data = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (in_sel == SEL_W'(i)) begin
                w_data = regs_flat[i*DATA_W +: DATA_W];
            end
        end
        if (in_sel == SEL_IMM) begin
            w_data = w_imm;
        end else if (in_sel == SEL_DIN) begin
            w_data = din;
        end
    end

    assign w_illegal = (32'(in_sel) >= 32'(NUM_REGS + 2));
    assign w_accept  = in_valid & in_ready;

    // Sticky error; a same-cycle clear lets the new illegal code be captured.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err     <= 1'b0;
            r_err_sel <= '0;
        end else begin
            if (err_clr) begin
                r_err     <= 1'b0;
                r_err_sel <= '0;
            end
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
                if (!r_err || err_clr) begin
                    r_err_sel <= in_sel;
                end
            end
        end
    end

    skid_fifo2 #(
        .W (PAY_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   ({in_sel, w_data}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_q),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_sel  = w_q[DATA_W +: SEL_W];
    assign out_data = w_q[DATA_W-1:0];
    assign err      = r_err;
    assign err_sel  = r_err_sel;

endmodule
